// File: rtl/qbus_dma_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : qbus_dma_sequencer                                                |
// | Qbus DMA master: arbitrates for the bus and runs DATI/DATO word cycles.    |
// | Optional macro QBUS_DMA_FAIR_EN: yield the bus every 4 words.              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module qbus_dma_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int ADDR_SETUP_CYC = 8,
  parameter int DESKEW_CYC     = 4,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [21:0] cmd_addr,
  input  logic [7:0]  cmd_count,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err_timeout,
  input  logic        brply_n,
  input  logic        bdmgi_n,
  input  logic        bsync_n_in,
  input  logic [15:0] bdal_in_n,
  output logic        bdmr,
  output logic        bsack,
  output logic        bsync,
  output logic        bdin,
  output logic        bdout,
  output logic [21:0] bdal_out,
  output logic        bdal_oe
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_REQ        = 4'd1,
    S_ACK        = 4'd2,
    S_ADDR       = 4'd3,
    S_SYNC       = 4'd4,
    S_DATA       = 4'd5,
    S_WAIT_RPLY  = 4'd6,
    S_WAIT_NRPLY = 4'd7,
    S_RELEASE    = 4'd8,
    S_FAIR       = 4'd9
  } state_t;

  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [21:0] r_addr;
  logic [8:0]  r_count;
  logic        r_write;
  logic [15:0] r_wdata;
  logic        r_rply_d;
  logic        r_cap;
  logic [15:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_err;
`ifdef QBUS_DMA_FAIR_EN
  logic [1:0]  r_words;
`endif

  // All bus receivers share one synchronizer pipe so data and RPLY age together.
  logic [18:0] r_sync [SYNC_STAGES];
  logic [18:0] w_sync;
  logic        w_rply, w_dmgi, w_sync_bus;
  logic [15:0] w_bdal;
  logic        w_timeout, w_word_done, w_tmo_hit;
  logic [15:0] w_wsel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
    end else begin
      r_sync[0] <= {brply_n, bdmgi_n, bsync_n_in, bdal_in_n};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync     = ~r_sync[SYNC_STAGES-1];
  assign w_rply     = w_sync[18];
  assign w_dmgi     = w_sync[17];
  assign w_sync_bus = w_sync[16];
  assign w_bdal     = w_sync[15:0];
  assign w_tmo_hit  = (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = S_REQ;
      S_REQ: begin
        if (w_dmgi && !w_sync_bus && !w_rply) w_next = S_ACK;
        else w_timeout = w_tmo_hit;
      end
      S_ACK: w_next = S_ADDR;
      S_ADDR: begin
        if (r_write && !wr_valid) w_timeout = w_tmo_hit;
        else if (r_cnt >= CW'(ADDR_SETUP_CYC - 1)) w_next = S_SYNC;
      end
      S_SYNC: if (r_cnt >= CW'(DESKEW_CYC - 1)) w_next = r_write ? S_DATA : S_WAIT_RPLY;
      S_DATA: if (r_cnt >= CW'(DESKEW_CYC - 1)) w_next = S_WAIT_RPLY;
      S_WAIT_RPLY: begin
        // Only a fresh RPLY edge counts; a level left high from before is stale.
        if (w_rply && !r_rply_d) w_next = S_WAIT_NRPLY;
        else w_timeout = w_tmo_hit;
      end
      S_WAIT_NRPLY: begin
        if (!w_rply) begin
          w_word_done = 1'b1;
          if (r_count == 9'd1) w_next = S_RELEASE;
`ifdef QBUS_DMA_FAIR_EN
          else if (r_words == 2'd3) w_next = S_FAIR;
`endif
          else w_next = S_ADDR;
        end else begin
          w_timeout = w_tmo_hit;
        end
      end
      S_RELEASE: w_next = S_IDLE;
`ifdef QBUS_DMA_FAIR_EN
      S_FAIR: if (r_cnt >= CW'(15)) w_next = S_REQ;
`endif
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  assign w_wsel = (r_cnt == '0) ? wr_data : r_wdata;

  always_comb begin
    cmd_ready = 1'b0;
    bdmr      = 1'b0;
    bsack     = 1'b0;
    bsync     = 1'b0;
    bdin      = 1'b0;
    bdout     = 1'b0;
    bdal_oe   = 1'b0;
    bdal_out  = '0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE:    cmd_ready = 1'b1;
      S_REQ:     bdmr = 1'b1;
      S_ACK:     bsack = 1'b1;
      S_ADDR: begin
        bsack    = 1'b1;
        bdal_oe  = 1'b1;
        bdal_out = r_addr;
      end
      S_SYNC: begin
        bsack    = 1'b1;
        bsync    = 1'b1;
        bdal_oe  = 1'b1;
        bdal_out = r_addr;
      end
      S_DATA: begin
        bsack    = 1'b1;
        bsync    = 1'b1;
        bdal_oe  = 1'b1;
        bdal_out = {6'b0, w_wsel};
        wr_ready = (r_cnt == '0);
      end
      S_WAIT_RPLY: begin
        bsack = 1'b1;
        bsync = 1'b1;
        if (r_write) begin
          bdal_oe  = 1'b1;
          bdal_out = {6'b0, r_wdata};
          bdout    = 1'b1;
        end else begin
          bdin = 1'b1;
        end
      end
      S_WAIT_NRPLY: begin
        bsack = 1'b1;
        bsync = 1'b1;
        if (r_write) begin
          bdal_oe  = 1'b1;
          bdal_out = {6'b0, r_wdata};
        end
      end
      S_RELEASE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_count    <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_rply_d   <= 1'b0;
      r_cap      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
`ifdef QBUS_DMA_FAIR_EN
      r_words    <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_rply_d   <= w_rply;
      r_rd_valid <= 1'b0;
      r_cap      <= 1'b0;
      if (w_next != r_state)      r_cnt <= '0;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;

      if (r_state == S_IDLE && cmd_valid) begin
        r_addr  <= cmd_addr & ~22'd1;
        r_count <= (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
        r_write <= cmd_write;
        r_err   <= 1'b0;
`ifdef QBUS_DMA_FAIR_EN
        r_words <= '0;
`endif
      end
      if (w_timeout) r_err <= 1'b1;
      if (r_state == S_DATA && r_cnt == '0) r_wdata <= wr_data;
      // Read data is sampled one cycle after RPLY is seen to give BDAL extra settle.
      if (r_state == S_WAIT_RPLY && w_next == S_WAIT_NRPLY && !r_write) r_cap <= 1'b1;
      if (r_cap) begin
        r_rd_data  <= w_bdal;
        r_rd_valid <= 1'b1;
      end
      if (w_word_done) begin
        r_addr  <= r_addr + 22'd2;
        r_count <= r_count - 9'd1;
`ifdef QBUS_DMA_FAIR_EN
        r_words <= r_words + 2'd1;
`endif
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qbus_dma_sequencer.sv
`default_nettype none
// Directed scoreboard bench for qbus_dma_sequencer with bus arbiter and slave models.
module tb_qbus_dma_sequencer;
  localparam int ADDR_SETUP = 8;
  localparam int DESKEW     = 4;
  localparam int TMO        = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [21:0] cmd_addr = '0;
  logic [7:0]  cmd_count = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, done, err_timeout;
  logic        brply_n, bdmgi_n, bsync_n_in;
  logic [15:0] bdal_in_n;
  logic        bdmr, bsack, bsync, bdin, bdout, bdal_oe;
  logic [21:0] bdal_out;

  assign bsync_n_in = ~bsync;

  qbus_dma_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err_timeout(err_timeout),
    .brply_n(brply_n), .bdmgi_n(bdmgi_n), .bsync_n_in(bsync_n_in), .bdal_in_n(bdal_in_n),
    .bdmr(bdmr), .bsack(bsack), .bsync(bsync), .bdin(bdin), .bdout(bdout),
    .bdal_out(bdal_out), .bdal_oe(bdal_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [21:0] q_addr[$];
  logic [15:0] q_wexp[$], q_rexp[$], q_rsrc[$], q_wsrc[$];

  int  n_rd, n_wr, n_done, n_sack_fall, n_bdmr_rise, rd_at_fall;
  int  pre_cnt = 0, sync_age = 0;
  logic p_bsync = 0, p_bdout = 0, p_bsack = 0, p_bdmr = 0;
  bit  grant_en = 1, rsp_stuck = 0, pop_pend = 0;
  int  rply_dly = 5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations as the DUT presents addresses/data.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bsync && !p_bsync) begin
      e = (q_addr.size() != 0) ? 32'(q_addr.pop_front()) : 32'h3FFFFF;
      chk("addr", 32'(bdal_out), e);
      chk("addr_setup", 32'(pre_cnt >= ADDR_SETUP), 32'd1);
    end
    if (bdout && !p_bdout) begin
      e = (q_wexp.size() != 0) ? 32'(q_wexp.pop_front()) : 32'h10000;
      chk("wdata", 32'(bdal_out), e);
      chk("deskew", 32'(sync_age), 32'(2 * DESKEW));
    end
    if (rd_valid) begin
      n_rd++;
      e = (q_rexp.size() != 0) ? 32'(q_rexp.pop_front()) : 32'h10000;
      chk("rdata", 32'(rd_data), e);
    end
    if (wr_ready) n_wr++;
    if (done) n_done++;
    if (!bsack && p_bsack) begin
      n_sack_fall++;
      if (n_sack_fall == 1) rd_at_fall = n_rd;
    end
    if (bdmr && !p_bdmr) n_bdmr_rise++;
    if (bdal_oe && !bsync) pre_cnt++; else pre_cnt = 0;
    if (!bsync) sync_age = 0; else if (!bdout) sync_age++;
    p_bsync = bsync; p_bdout = bdout; p_bsack = bsack; p_bdmr = bdmr;
  end

  // Write-data source: advances one word after each wr_ready handshake.
  initial forever begin
    @(negedge clk);
    if (wr_ready) pop_pend = 1;
    @(posedge clk); #1;
    if (pop_pend && q_wsrc.size() != 0) void'(q_wsrc.pop_front());
    pop_pend = 0;
    wr_valid = (q_wsrc.size() != 0);
    wr_data  = wr_valid ? q_wsrc[0] : 16'h0;
  end

  // Bus arbiter: grants 10 clocks after BDMR, withdraws when BSACK appears.
  initial begin
    bdmgi_n = 1'b1;
    forever begin
      @(negedge clk);
      if (bdmr && grant_en) begin
        repeat (10) @(negedge clk);
        bdmgi_n = 1'b0;
        for (int k = 0; k < 200 && !bsack && !reset; k++) @(negedge clk);
        bdmgi_n = 1'b1;
      end
    end
  end

  // Memory slave: replies rply_dly clocks after BDIN/BDOUT.
  initial begin
    bit rd_cyc;
    logic [15:0] w;
    brply_n   = 1'b1;
    bdal_in_n = '1;
    forever begin
      @(negedge clk);
      if (bdin || bdout) begin
        rd_cyc = bdin;
        repeat (rply_dly) @(negedge clk);
        if (rd_cyc) begin
          w = 16'hDEAD;
          if (q_rsrc.size() != 0) w = q_rsrc.pop_front();
          bdal_in_n = ~w;
        end
        brply_n = 1'b0;
        for (int k = 0; k < 3000 && (bdin || bdout); k++) @(negedge clk);
        for (int k = 0; k < 3000 && rsp_stuck; k++) @(negedge clk);
        @(negedge clk);
        brply_n   = 1'b1;
        bdal_in_n = '1;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clr_mon();
    n_rd = 0; n_wr = 0; n_done = 0; n_sack_fall = 0; n_bdmr_rise = 0; rd_at_fall = -1;
  endtask

  task automatic issue(input bit wr, input logic [21:0] a, input logic [7:0] c);
    cmd_write = wr; cmd_addr = a; cmd_count = c; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if ((n_done > 0 || err_timeout) && cmd_ready) begin ok = 1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    clr_mon();
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_bus", {26'd0, bdmr, bsack, bsync, bdin, bdout, bdal_oe}, 32'd0);
    chk("rst_bdal", 32'(bdal_out), 32'd0);
    chk("rst_flags", {28'd0, done, rd_valid, wr_ready, err_timeout}, 32'd0);

    // DATI, 1 word
    clr_mon();
    q_addr.push_back(22'h001000); q_rsrc.push_back(16'h1234); q_rexp.push_back(16'h1234);
    issue(1'b0, 22'h001000, 8'd1);
    wait_end("dati1_end", 300);
    step();
    chk("dati1_rd", 32'(n_rd), 32'd1);
    chk("dati1_done", 32'(n_done), 32'd1);
    chk("dati1_sack", 32'(bsack), 32'd0);

    // DATO, 3 words across the 22-bit wrap
    clr_mon();
    q_addr.push_back(22'h3FFFFC); q_addr.push_back(22'h3FFFFE); q_addr.push_back(22'h000000);
    q_wexp.push_back(16'hA5A5); q_wexp.push_back(16'h5A5A); q_wexp.push_back(16'hFFFF);
    q_wsrc.push_back(16'hA5A5); q_wsrc.push_back(16'h5A5A); q_wsrc.push_back(16'hFFFF);
    issue(1'b1, 22'h3FFFFC, 8'd3);
    wait_end("dato3_end", 600);
    step();
    chk("dato3_wr", 32'(n_wr), 32'd3);
    chk("dato3_done", 32'(n_done), 32'd1);
    chk("dato3_qempty", 32'(q_addr.size() + q_wexp.size() + q_wsrc.size()), 32'd0);

    // DATI count=0 (256 words), odd start address has bit0 forced to 0
    clr_mon();
    for (int k = 0; k < 256; k++) begin
      logic [15:0] d;
      d = 16'(k * 16'h0101) ^ 16'h005A;
      q_addr.push_back(22'h000100 + 22'(2 * k));
      q_rsrc.push_back(d); q_rexp.push_back(d);
    end
    issue(1'b0, 22'h000101, 8'd0);
    wait_end("dati256_end", 20000);
    chk("dati256_rd", 32'(n_rd), 32'd256);
    chk("dati256_done", 32'(n_done), 32'd1);
    chk("dati256_qempty", 32'(q_addr.size() + q_rexp.size()), 32'd0);

    // No grant: timeout after 1024 clocks in REQ
    clr_mon();
    grant_en = 0;
    issue(1'b0, 22'h000400, 8'd1);
    repeat (TMO - 1) step();
    chk("nogrant_early", 32'(err_timeout), 32'd0);
    step();
    chk("nogrant_err", 32'(err_timeout), 32'd1);
    chk("nogrant_bdmr", 32'(bdmr), 32'd0);
    chk("nogrant_ready", 32'(cmd_ready), 32'd1);
    chk("nogrant_done", 32'(n_done), 32'd0);
    grant_en = 1;
    step();

    // Responder never releases BRPLY: timeout in WAIT_NRPLY
    clr_mon();
    rsp_stuck = 1;
    q_addr.push_back(22'h000800); q_rsrc.push_back(16'h0F0F); q_rexp.push_back(16'h0F0F);
    issue(1'b0, 22'h000800, 8'd1);
    chk("stuck_errclr", 32'(err_timeout), 32'd0);
    begin
      bit seen = 0;
      for (int k = 0; k < 1400; k++) begin
        step();
        if (err_timeout) begin seen = 1; break; end
      end
      chk("stuck_err", 32'(seen), 32'd1);
    end
    chk("stuck_bus", {29'd0, bsync, bsack, bdal_oe}, 32'd0);
    chk("stuck_rd", 32'(n_rd), 32'd1);
    chk("stuck_done", 32'(n_done), 32'd0);
    rsp_stuck = 0;
    repeat (20) step();

    // Reset asserted during WAIT_RPLY of a DATO
    clr_mon();
    rply_dly = 60;
    q_addr.push_back(22'h000200); q_wexp.push_back(16'hC3C3); q_wsrc.push_back(16'hC3C3);
    issue(1'b1, 22'h000200, 8'd1);
    begin
      bit seen = 0;
      for (int k = 0; k < 300; k++) begin
        step();
        if (bdout) begin seen = 1; break; end
      end
      chk("rstmid_bdout_seen", 32'(seen), 32'd1);
    end
    #1 reset = 1'b1;
    #1 chk("rstmid_bus", {28'd0, bdout, bsync, bsack, bdal_oe}, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rstmid_ready", 32'(cmd_ready), 32'd1);
    repeat (80) step();
    rply_dly = 5;

`ifdef QBUS_DMA_FAIR_EN
    // Fair sharing: DATI 8 words yields the bus once after word 4
    clr_mon();
    for (int k = 0; k < 8; k++) begin
      q_addr.push_back(22'h002000 + 22'(2 * k));
      q_rsrc.push_back(16'(16'h1100 + k)); q_rexp.push_back(16'(16'h1100 + k));
    end
    issue(1'b0, 22'h002000, 8'd8);
    wait_end("fair_end", 1500);
    step();
    chk("fair_rd", 32'(n_rd), 32'd8);
    chk("fair_done", 32'(n_done), 32'd1);
    chk("fair_sackfall", 32'(n_sack_fall), 32'd2);
    chk("fair_yield_at", 32'(rd_at_fall), 32'd4);
    chk("fair_bdmr", 32'(n_bdmr_rise), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qbus_dma_sequencer.md
Name: qbus_dma_sequencer

Overview:
- Clocked Qbus DMA master sequencer. Replaces firmware bit-banging of the bus-control register: the H723 posts one command (direction, 22-bit start address, word count, write data stream); the block arbitrates for the bus and runs the DATI/DATO cycles.
- Sits between the FMC register file and the Qbus gate drivers/receivers.
- All Qbus inputs are asynchronous and synchronized internally.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per async Qbus input.
- ADDR_SETUP_CYC, 8: clk cycles address is driven before BSYNC asserts (>=150 ns at 50 MHz).
- DESKEW_CYC, 4: clk cycles between BSYNC/data-valid and BDIN/BDOUT assertion.
- TIMEOUT_CYC, 1024: max clk cycles waiting on any bus event before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1=DATO (write to PDP-11 memory), 0=DATI
- cmd_addr  in  22  start byte address; bit0 ignored (forced 0)
- cmd_count  in  8  words to transfer; 0 means 256
- wr_data  in  16  next write word
- wr_valid  in  1  write word available
- wr_ready  out  1  one-cycle pulse when wr_data is consumed
- rd_data  out  16  read word, true polarity
- rd_valid  out  1  one-cycle pulse per read word
- done  out  1  one-cycle pulse at normal completion
- err_timeout  out  1  sticky; cleared by next cmd_valid accept
- brply_n, bdmgi_n, bsync_n_in  in  1 each  raw active-low bus receivers
- bdal_in_n  in  16  raw active-low BDAL receivers
- bdmr, bsack, bsync, bdin, bdout  out  1 each  gate drives, active-high
- bdal_out  out  22  true-polarity output data/address
- bdal_oe  out  1  enables FPGA drivers and BDAL gate drivers

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE; counters 0; err_timeout=0.
- Inputs pass through SYNC_STAGES flops before use; rply/dmgi/sync below mean synchronized, active-high.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/count/dir, clear err_timeout, go to REQ.
- REQ: bdmr=1. When dmgi && !sync && !rply, go to ACK.
- ACK: bsack=1, bdmr=0 in the same cycle. Go to ADDR.
- ADDR: bdal_oe=1, bdal_out=addr. Held ADDR_SETUP_CYC cycles. For a write, also waits for wr_valid, since the data word must be ready before BSYNC.
- SYNC: bsync=1, address held for DESKEW_CYC cycles.
- Write data phase: bdal_out={6'b0,wr_data}, wr_ready pulses at entry. After DESKEW_CYC, bdout=1.
- Read data phase: bdal_oe=0, bdin=1 immediately.
- WAIT_RPLY: wait for rply.
  - Read: on rply, capture ~bdal_in_n (through the synchronizer pipe plus one extra sample cycle), pulse rd_valid, drop bdin.
  - Write: on rply, drop bdout.
- WAIT_NRPLY: wait for !rply, then bsync=0 and bdal_oe=0.
  - Word-complete point: addr+=2, count-=1.
  - If count!=0, go to ADDR; otherwise go to RELEASE.
- Address arithmetic: 22-bit wrap (0x3FFFFE+2 -> 0x000000), no error.
- RELEASE: bsack=0, done pulses, go to IDLE.
- Timeout:
  - Armed in REQ, WAIT_RPLY, WAIT_NRPLY, and in ADDR while waiting for wr_valid.
  - Counter resets on each state entry; reaching TIMEOUT_CYC sets err_timeout.
  - Drops all bus outputs in one cycle and returns to IDLE; done stays 0.
- Simultaneous events:
  - rply already high on entry to WAIT_RPLY (stale) is not accepted; WAIT_NRPLY of the previous word guarantees rply was low.
  - cmd_valid while busy is ignored (cmd_ready=0).
- Reset mid-transfer: all bus drives drop asynchronously; no partial-word reporting.

Optional Feature:
- Macro QBUS_DMA_FAIR_EN.
- Defined: after every 4 completed words with count!=0, go to RELEASE-without-done:
  - drop bsack;
  - wait 16 clk;
  - re-enter REQ with current addr/count.
  - done pulses only at the true end.
- Undefined: bus held for the whole transfer.

Test Plan:
- DATI 1 word at 0x001000:
  - grant after 10 clk; responder drives bdal_in_n=~16'h1234 and asserts brply_n at 5 clk after bdin.
  - Required: rd_data=16'h1234, rd_valid 1 pulse, done 1 pulse, bsack low after.
- DATO 3 words from 0x3FFFFC, data A5A5/5A5A/FFFF:
  - Required: addresses 0x3FFFFC, 0x3FFFFE, 0x000000 on bdal_out; 3 wr_ready pulses; bdout only after ADDR_SETUP+DESKEW; done once.
- No grant:
  - Required: err_timeout=1 after 1024 clk in REQ, bdmr=0, cmd_ready=1, done=0.
- Responder never deasserts brply_n:
  - Required: timeout in WAIT_NRPLY, bsync/bsack/bdal_oe all 0 the next cycle.
- Reset asserted during WAIT_RPLY of a DATO:
  - Required: bdout, bsync, bsack, bdal_oe=0 with no clk edge; IDLE after release.
- With QBUS_DMA_FAIR_EN defined, DATI count=8:
  - Required: bsack drops once between words 4 and 5; bdmr re-asserted; 8 rd_valid pulses; 1 done pulse.
